pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register for the P7 five-stage MIPS core; replaces per-stage hand-written D/E/M/W registers.
//  Carries instr/pc/payload plus exception state (excCode, branch-delay flag) and a valid bit. Resolves exception redirect, stall-bubble, flush, load and hold.
//  Merges a locally detected exception into the carried code (first exception wins). Counts stall bubbles for the performance counters.
// PARAMETERS
//  PAYLOAD_W    96            width of opaque per-stage data (e.g. {EXT,rs,rt})
//  EXC_W        5             exception code width; 0 = no exception
//  HANDLER_PC   32'h0000_4180 pc loaded on exception request
//  RESET_PC     32'h0000_0000 pc_out value after reset / flush
//  CNT_W        16            bubble counter width
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          asynchronous, active-high reset
//  req           in   1          exception/interrupt request from CP0: squash and redirect
//  stall         in   1          hazard unit: upstream stalled, insert bubble here
//  flush         in   1          squash contents (e.g. eret / annulled slot)
//  we            in   1          load enable; 0 = hold current contents
//  instr_in      in   32         instruction word
//  pc_in         in   32         instruction pc
//  payload_in    in   PAYLOAD_W  opaque stage data
//  exc_in        in   EXC_W      exception code from upstream register
//  exc_local_in  in   EXC_W      exception detected in the stage feeding this register
//  bd_in         in   1          instruction is in a branch delay slot
//  cnt_clr       in   1          synchronous clear of bubble_cnt
//  instr_out     out  32         registered instr
//  pc_out        out  32         registered pc
//  payload_out   out  PAYLOAD_W  registered payload
//  exc_out       out  EXC_W      registered (merged) exception code
//  bd_out        out  1          registered delay-slot flag
//  valid_out     out  1          1 = register holds a real instruction
//  bubble_cnt    out  CNT_W      saturating count of stall-bubble cycles
// BEHAVIOUR
//  Reset (async, immediate): instr/payload/exc/bd/valid = 0, pc = RESET_PC, bubble_cnt = 0.
//  One update per rising edge, priority req > stall > flush > we > hold:
//   req:   instr/payload/exc/bd/valid <= 0; pc <= HANDLER_PC.
//   stall: bubble: instr/payload/exc/valid <= 0; pc <= pc_in; bd <= bd_in (keeps EPC/BD for a later interrupt).
//   flush: instr/payload/exc/bd/valid <= 0; pc <= RESET_PC.
//   we:    load all *_in; valid <= 1; exc <= (exc_in != 0) ? exc_in : exc_local_in.
//   else:  all outputs hold.
//  Merge rule: upstream code always wins; exc_local_in is ignored when exc_in != 0.
//  Latency 1 cycle; outputs purely registered, no combinational in->out path.
//  bubble_cnt: +1 on every edge where stall=1 and req=0; saturates at 2^CNT_W-1 (no wrap).
//   cnt_clr=1 zeroes it, overriding an increment in the same cycle; bubble_cnt is unaffected by req/flush/we.
//  Simultaneous req+stall: req wins (pc = HANDLER_PC, bd = 0), no count.
//  Simultaneous stall+flush: stall wins (pc_in/bd_in kept).
//  Reset asserted mid-operation clears everything asynchronously; first edge after release obeys normal priority.
//  bubble output (stall) has valid_out=0 but pc_out=pc_in, so CP0 still sees a meaningful EPC.
// TESTING
//  T1 reset high mid-stream (we=1 loading) -> same cycle, without clock edge: all outputs 0, pc_out=RESET_PC, bubble_cnt=0.
//  T2 we=1, instr_in=32'h2408_0001, pc_in=32'h3004, exc_in=0, exc_local_in=5'd4, bd_in=1 -> next edge: instr_out=32'h2408_0001, pc_out=32'h3004, exc_out=4, bd_out=1, valid_out=1.
//  T3 stall=1, pc_in=32'h3008, bd_in=1 -> instr_out=0, pc_out=32'h3008, bd_out=1, valid_out=0, exc_out=0, bubble_cnt +1.
//  T4 req=1 with stall=1, pc_in=32'h300c -> pc_out=32'h4180, instr_out=0, bd_out=0, valid_out=0, bubble_cnt unchanged.
//  T5 we=1, exc_in=5'd12, exc_local_in=5'd10 -> exc_out=12; then we=0 for 3 cycles -> all outputs hold.
//  T6 CNT_W=2, stall=1 for 5 cycles -> bubble_cnt 1,2,3,3,3; then stall=1 with cnt_clr=1 -> bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Bundle of the control, data and status signals between a pipeline stage and
// its inter-stage register.
//   master : stage / hazard unit / CP0 side, drives req/stall/flush/we/cnt_clr
//            and the *_in fields, and observes the *_out fields and bubble_cnt
//   slave  : pipe_stage_reg side, the mirror image
interface pipe_stage_reg_if #(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned EXC_W     = 5,
    parameter int unsigned CNT_W     = 16
);
    logic                 req;
    logic                 stall;
    logic                 flush;
    logic                 we;
    logic                 cnt_clr;
    logic [31:0]          instr_in;
    logic [31:0]          pc_in;
    logic [PAYLOAD_W-1:0] payload_in;
    logic [EXC_W-1:0]     exc_in;
    logic [EXC_W-1:0]     exc_local_in;
    logic                 bd_in;

    logic [31:0]          instr_out;
    logic [31:0]          pc_out;
    logic [PAYLOAD_W-1:0] payload_out;
    logic [EXC_W-1:0]     exc_out;
    logic                 bd_out;
    logic                 valid_out;
    logic [CNT_W-1:0]     bubble_cnt;

    modport master (
        output req, stall, flush, we, cnt_clr,
        output instr_in, pc_in, payload_in, exc_in, exc_local_in, bd_in,
        input  instr_out, pc_out, payload_out, exc_out, bd_out, valid_out, bubble_cnt
    );

    modport slave (
        input  req, stall, flush, we, cnt_clr,
        input  instr_in, pc_in, payload_in, exc_in, exc_local_in, bd_in,
        output instr_out, pc_out, payload_out, exc_out, bd_out, valid_out, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the five-stage MIPS core.
// Carries instr/pc/payload plus exception code, branch-delay flag and a valid
// bit; resolves exception redirect, stall bubble, flush, load and hold with
// priority req > stall > flush > we > hold. A locally detected exception is
// merged into the carried code (upstream code wins). Stall bubbles are counted
// in a saturating counter for the performance counters.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : pipe_stage_reg_if.slave (controls, *_in fields, registered
//            *_out fields, bubble_cnt)
// All outputs are registered; there is no combinational input-to-output path.
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W  = 96,
    parameter int unsigned EXC_W      = 5,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_stage_reg_if.slave       bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]          instr_q;
    logic [31:0]          pc_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [EXC_W-1:0]     exc_q;
    logic                 bd_q;
    logic                 valid_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [EXC_W-1:0]     exc_merged_c;
    logic                 cnt_inc_c;

    // First exception wins: an upstream code masks the locally detected one.
    always_comb begin
        exc_merged_c = bus.exc_local_in;
        if (bus.exc_in != '0) begin
            exc_merged_c = bus.exc_in;
        end
    end

    // A bubble is counted only when the stall is not overridden by req.
    assign cnt_inc_c = bus.stall && !bus.req;

    // Pipeline contents with the redirect/bubble/flush/load/hold priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= '0;
            pc_q      <= RESET_PC;
            payload_q <= '0;
            exc_q     <= '0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.req) begin
            instr_q   <= '0;
            pc_q      <= HANDLER_PC;
            payload_q <= '0;
            exc_q     <= '0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.stall) begin
            // Bubble keeps pc/bd so CP0 still sees a meaningful EPC/BD.
            instr_q   <= '0;
            pc_q      <= bus.pc_in;
            payload_q <= '0;
            exc_q     <= '0;
            bd_q      <= bus.bd_in;
            valid_q   <= 1'b0;
        end else if (bus.flush) begin
            instr_q   <= '0;
            pc_q      <= RESET_PC;
            payload_q <= '0;
            exc_q     <= '0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.we) begin
            instr_q   <= bus.instr_in;
            pc_q      <= bus.pc_in;
            payload_q <= bus.payload_in;
            exc_q     <= exc_merged_c;
            bd_q      <= bus.bd_in;
            valid_q   <= 1'b1;
        end
    end

    // Saturating bubble counter; clear overrides a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.pc_out      = pc_q;
    assign bus.payload_out = payload_q;
    assign bus.exc_out     = exc_q;
    assign bus.bd_out      = bd_q;
    assign bus.valid_out   = valid_q;
    assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one default-width instance (dut_a) and a
// CNT_W=2 instance (dut_b) for counter saturation.
module tb_pipe_stage_reg;

    localparam int unsigned PW = 96;
    localparam int unsigned EW = 5;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipe_stage_reg_if #(.PAYLOAD_W(PW), .EXC_W(EW), .CNT_W(16)) ifa ();
    pipe_stage_reg_if #(.PAYLOAD_W(PW), .EXC_W(EW), .CNT_W(2))  ifb ();

    pipe_stage_reg #(.PAYLOAD_W(PW), .EXC_W(EW), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    pipe_stage_reg #(.PAYLOAD_W(PW), .EXC_W(EW), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.req = 0; ifa.stall = 0; ifa.flush = 0; ifa.we = 0; ifa.cnt_clr = 0;
        ifa.instr_in = '0; ifa.pc_in = '0; ifa.payload_in = '0;
        ifa.exc_in = '0; ifa.exc_local_in = '0; ifa.bd_in = 0;
    endtask

    task automatic idle_b();
        ifb.req = 0; ifb.stall = 0; ifb.flush = 0; ifb.we = 0; ifb.cnt_clr = 0;
        ifb.instr_in = '0; ifb.pc_in = '0; ifb.payload_in = '0;
        ifb.exc_in = '0; ifb.exc_local_in = '0; ifb.bd_in = 0;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [EW-1:0] exc, input logic bd, input logic valid,
                         input logic [15:0] cnt);
        chk({tag, ".instr"}, 128'(ifa.instr_out), 128'(instr));
        chk({tag, ".pc"},    128'(ifa.pc_out),    128'(pc));
        chk({tag, ".exc"},   128'(ifa.exc_out),   128'(exc));
        chk({tag, ".bd"},    128'(ifa.bd_out),    128'(bd));
        chk({tag, ".valid"}, 128'(ifa.valid_out), 128'(valid));
        chk({tag, ".cnt"},   128'(ifa.bubble_cnt), 128'(cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_a();
        idle_b();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_a("rst0", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd0);
        chk("rst0.payload", 128'(ifa.payload_out), 128'(0));

        // Bubble with no prior content, to make the counter nonzero.
        ifa.stall = 1; ifa.pc_in = 32'h0000_0100;
        step();
        chk_a("pre_stall", 32'h0, 32'h0000_0100, 5'd0, 1'b0, 1'b0, 16'd1);

        // Load a word, then hit async reset mid-load without a clock edge (T1).
        idle_a();
        ifa.we = 1; ifa.instr_in = 32'hdead_beef; ifa.pc_in = 32'h0000_0200;
        ifa.payload_in = 96'h1234_5678_9abc_def0_1111_2222; ifa.exc_local_in = 5'd3; ifa.bd_in = 1;
        step();
        chk_a("load0", 32'hdead_beef, 32'h0000_0200, 5'd3, 1'b1, 1'b1, 16'd1);
        chk("load0.payload", 128'(ifa.payload_out), 128'(96'h1234_5678_9abc_def0_1111_2222));
        #1 reset = 1'b1;
        #1;
        chk_a("T1", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd0);
        chk("T1.payload", 128'(ifa.payload_out), 128'(0));
        #1 reset = 1'b0;

        // T2: load with local exception merged in (upstream code is zero).
        idle_a();
        ifa.we = 1; ifa.instr_in = 32'h2408_0001; ifa.pc_in = 32'h0000_3004;
        ifa.payload_in = 96'habc; ifa.exc_in = 5'd0; ifa.exc_local_in = 5'd4; ifa.bd_in = 1;
        step();
        chk_a("T2", 32'h2408_0001, 32'h0000_3004, 5'd4, 1'b1, 1'b1, 16'd0);
        chk("T2.payload", 128'(ifa.payload_out), 128'(96'habc));

        // T3: stall beats flush and we; bubble keeps pc_in/bd_in.
        idle_a();
        ifa.stall = 1; ifa.flush = 1; ifa.we = 1; ifa.instr_in = 32'h1111_1111;
        ifa.pc_in = 32'h0000_3008; ifa.bd_in = 1; ifa.exc_in = 5'd7;
        step();
        chk_a("T3", 32'h0, 32'h0000_3008, 5'd0, 1'b1, 1'b0, 16'd1);
        chk("T3.payload", 128'(ifa.payload_out), 128'(0));

        // T4: req beats stall, redirects to handler, no count.
        idle_a();
        ifa.req = 1; ifa.stall = 1; ifa.pc_in = 32'h0000_300c; ifa.bd_in = 1;
        step();
        chk_a("T4", 32'h0, 32'h0000_4180, 5'd0, 1'b0, 1'b0, 16'd1);

        // T5: upstream exception code wins over local one; then hold 3 cycles.
        idle_a();
        ifa.we = 1; ifa.instr_in = 32'h8c08_0010; ifa.pc_in = 32'h0000_3010;
        ifa.payload_in = 96'h5555; ifa.exc_in = 5'd12; ifa.exc_local_in = 5'd10; ifa.bd_in = 0;
        step();
        chk_a("T5", 32'h8c08_0010, 32'h0000_3010, 5'd12, 1'b0, 1'b1, 16'd1);
        idle_a();
        ifa.instr_in = 32'hffff_ffff; ifa.pc_in = 32'hffff_fff0; ifa.payload_in = '1;
        ifa.exc_in = 5'd31; ifa.bd_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("T5hold", 32'h8c08_0010, 32'h0000_3010, 5'd12, 1'b0, 1'b1, 16'd1);
            chk("T5hold.payload", 128'(ifa.payload_out), 128'(96'h5555));
        end

        // Flush beats we: squash to RESET_PC, counter untouched.
        idle_a();
        ifa.flush = 1; ifa.we = 1; ifa.instr_in = 32'h2222_2222; ifa.pc_in = 32'h0000_3014; ifa.bd_in = 1;
        step();
        chk_a("flush", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd1);

        // Clear without stall.
        idle_a();
        ifa.cnt_clr = 1;
        step();
        chk("clr.cnt", 128'(ifa.bubble_cnt), 128'(16'd0));
        idle_a();

        // T6: 2-bit counter saturates at 3, then clear overrides increment.
        ifb.stall = 1; ifb.pc_in = 32'h0000_5000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("T6.cnt", 128'(ifb.bubble_cnt), 128'((i < 3) ? (i + 1) : 3));
        end
        chk("T6.valid", 128'(ifb.valid_out), 128'(0));
        chk("T6.pc", 128'(ifb.pc_out), 128'(32'h0000_5000));
        ifb.cnt_clr = 1;
        step();
        chk("T6.clr", 128'(ifb.bubble_cnt), 128'(0));
        idle_b();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
